// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_check_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } tt_state_e;

  // Three DUT inputs give eight vectors, indexed as {a,b,c}
  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  // Full-adder reference tables: bit i is the expected output for vector i
  localparam logic [NUM_VEC-1:0] FA_SUM   = 8'h96;
  localparam logic [NUM_VEC-1:0] FA_CARRY = 8'hE8;

  // A vector fails when either observed output differs from its table bit;
  // both wrong still counts as a single failing vector.
  function automatic logic vecMismatch(
    input logic [NUM_VEC-1:0] expX,
    input logic [NUM_VEC-1:0] expY,
    input logic [VEC_W-1:0]   idx,
    input logic               obsX,
    input logic               obsY
  );
    return (obsX != expX[idx]) || (obsY != expY[idx]);
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: counts how long the current vector has been applied and
// flags the cycle on which the DUT outputs should be sampled.
module settle_timer
  import tt_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [CNT_W-1:0] r_count;

  // Count while enabled; clear restarts the hold period for a new vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal count marks the last hold cycle of the current vector
  assign o_terminal = (r_count == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: walks {a,b,c} through all eight vectors, samples the
// DUT outputs x,y after a settle delay, and records pass/fail results.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] EXP_X         = FA_SUM,
  parameter logic [NUM_VEC-1:0] EXP_Y         = FA_CARRY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             x,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_idx
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

  tt_state_e        r_state;
  tt_state_e        w_stateNext;
  logic [VEC_W-1:0] r_idx;
  logic [VEC_W-1:0] r_abc;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [3:0]       r_errCount;
  logic             r_ffValid;
  logic [VEC_W-1:0] r_ffIdx;

  logic             w_accept;
  logic             w_sample;
  logic             w_terminal;
  logic             w_fail;
  logic [3:0]       w_errNext;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (4)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept | w_sample),
    .i_enable   (r_state == SETTLE),
    .o_terminal (w_terminal)
  );

  assign w_fail    = vecMismatch(EXP_X, EXP_Y, r_idx, x, y);
  assign w_errNext = r_errCount + {3'b000, w_fail};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; start is only honoured outside an active sweep
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = SETTLE;
        end
      end
      SETTLE: begin
        if (w_terminal) begin
          w_sample = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_stateNext = DONE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Vector drive and result registers, updated on start and sampling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_abc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_errCount <= '0;
      r_ffValid  <= 1'b0;
      r_ffIdx    <= '0;
    end else if (w_accept) begin
      r_idx      <= '0;
      r_abc      <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_errCount <= '0;
      r_ffValid  <= 1'b0;
      r_ffIdx    <= '0;
    end else if (w_sample) begin
      r_errCount <= w_errNext;
      if (w_fail && !r_ffValid) begin
        r_ffValid <= 1'b1;
        r_ffIdx   <= r_idx;
      end
      if (r_idx == LAST_IDX) begin
        r_abc  <= '0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_errNext == 4'd0);
      end else begin
        r_idx <= r_idx + 1'b1;
        r_abc <= r_idx + 1'b1;
      end
    end
  end

  assign {a, b, c}        = r_abc;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_errCount;
  assign first_fail_valid = r_ffValid;
  assign first_fail_idx   = r_ffIdx;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a behavioural full-adder DUT
// that can be faulted (y stuck low, x inverted).
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       a, b, c, x, y, busy, done, pass, ffv;
  logic [3:0] err;
  logic [2:0] ffi;

  logic       a1, b1, c1, x1, y1, busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [2:0] ffi1;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  // Full-adder lab block; mode 1 holds carry at 0, mode 2 inverts sum
  assign x = (a ^ b ^ c) ^ (mode == 2'd2);
  assign y = ((a & b) | (a & c) | (b & c)) & (mode != 2'd1);

  // Always-correct full adder for the single-cycle-settle instance
  assign x1 = a1 ^ b1 ^ c1;
  assign y1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  truth_table_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .x(x), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_valid(ffv), .first_fail_idx(ffi)
  );

  truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_idx(ffi1)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start for one edge; returns at the negedge just after that edge
  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which == 0) start = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    $display("[TB] reset");
    waitEdges(2);
    checkOutput("rst_abc", {5'b0, a, b, c}, 8'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_pass", pass, 1'b0);
    checkOutput("rst_err", err, 4'd0);
    checkOutput("rst_ffv", ffv, 1'b0);
    checkOutput("rst_done1", done1, 1'b0);
    rst = 1'b0;
    waitEdges(1);

    $display("[TB] correct full adder, settle 2");
    applyStimulus(0);
    for (int n = 0; n < 16; n++) begin
      if (n > 0) waitEdges(1);
      checkOutput($sformatf("s1_abc_e%0d", n), {5'b0, a, b, c}, 8'(n / 2));
      checkOutput($sformatf("s1_busy_e%0d", n), busy, 1'b1);
      checkOutput($sformatf("s1_done_e%0d", n), done, 1'b0);
    end
    waitEdges(1);
    checkOutput("s1_done", done, 1'b1);
    checkOutput("s1_busy_end", busy, 1'b0);
    checkOutput("s1_pass", pass, 1'b1);
    checkOutput("s1_err", err, 4'd0);
    checkOutput("s1_ffv", ffv, 1'b0);
    checkOutput("s1_abc_end", {5'b0, a, b, c}, 8'd0);

    $display("[TB] y stuck at 0");
    mode = 2'd1;
    applyStimulus(0);
    checkOutput("s2_done_drop", done, 1'b0);
    checkOutput("s2_busy", busy, 1'b1);
    waitEdges(16);
    checkOutput("s2_done", done, 1'b1);
    checkOutput("s2_err", err, 4'd4);
    checkOutput("s2_ffv", ffv, 1'b1);
    checkOutput("s2_ffi", ffi, 3'd3);
    checkOutput("s2_pass", pass, 1'b0);

    $display("[TB] x inverted");
    mode = 2'd2;
    applyStimulus(0);
    checkOutput("s3_err_clear", err, 4'd0);
    checkOutput("s3_ffv_clear", ffv, 1'b0);
    waitEdges(1);
    checkOutput("s3_ffv_e1", ffv, 1'b0);
    waitEdges(1);
    checkOutput("s3_ffv_e2", ffv, 1'b1);
    checkOutput("s3_err_e2", err, 4'd1);
    waitEdges(14);
    checkOutput("s3_done", done, 1'b1);
    checkOutput("s3_err", err, 4'd8);
    checkOutput("s3_ffi", ffi, 3'd0);
    checkOutput("s3_pass", pass, 1'b0);

    $display("[TB] restart from done with correct model");
    mode = 2'd0;
    applyStimulus(0);
    checkOutput("s3b_done_drop", done, 1'b0);
    checkOutput("s3b_pass_drop", pass, 1'b0);
    waitEdges(15);
    checkOutput("s3b_done_e15", done, 1'b0);
    waitEdges(1);
    checkOutput("s3b_done", done, 1'b1);
    checkOutput("s3b_pass", pass, 1'b1);
    checkOutput("s3b_err", err, 4'd0);

    $display("[TB] reset mid-sweep");
    applyStimulus(0);
    waitEdges(6);
    checkOutput("s4_abc_e6", {5'b0, a, b, c}, 8'd3);
    rst = 1'b1;
    waitEdges(1);
    rst = 1'b0;
    checkOutput("s4_abc_rst", {5'b0, a, b, c}, 8'd0);
    checkOutput("s4_busy_rst", busy, 1'b0);
    checkOutput("s4_done_rst", done, 1'b0);
    checkOutput("s4_err_rst", err, 4'd0);
    waitEdges(2);
    checkOutput("s4_idle_busy", busy, 1'b0);
    checkOutput("s4_idle_abc", {5'b0, a, b, c}, 8'd0);
    applyStimulus(0);
    waitEdges(15);
    checkOutput("s4_done_e15", done, 1'b0);
    waitEdges(1);
    checkOutput("s4_done", done, 1'b1);
    checkOutput("s4_pass", pass, 1'b1);

    $display("[TB] reset and start together");
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("s4b_busy", busy, 1'b0);
    checkOutput("s4b_done", done, 1'b0);
    waitEdges(2);
    checkOutput("s4b_busy_later", busy, 1'b0);

    $display("[TB] start re-pulsed mid-sweep");
    applyStimulus(0);
    checkOutput("s5_abc_e0", {5'b0, a, b, c}, 8'd0);
    for (int n = 1; n < 16; n++) begin
      waitEdges(1);
      checkOutput($sformatf("s5_abc_e%0d", n), {5'b0, a, b, c}, 8'(n / 2));
      if (n == 2 || n == 8) start = 1'b1;
      if (n == 3 || n == 9) start = 1'b0;
    end
    checkOutput("s5_done_e15", done, 1'b0);
    waitEdges(1);
    checkOutput("s5_done", done, 1'b1);
    checkOutput("s5_pass", pass, 1'b1);
    checkOutput("s5_err", err, 4'd0);

    $display("[TB] settle 1 instance");
    applyStimulus(1);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) waitEdges(1);
      checkOutput($sformatf("s6_abc_e%0d", n), {5'b0, a1, b1, c1}, 8'(n));
      checkOutput($sformatf("s6_done_e%0d", n), done1, 1'b0);
    end
    waitEdges(1);
    checkOutput("s6_done", done1, 1'b1);
    checkOutput("s6_busy", busy1, 1'b0);
    checkOutput("s6_pass", pass1, 1'b1);
    checkOutput("s6_err", err1, 4'd0);
    checkOutput("s6_ffv", ffv1, 1'b0);
    checkOutput("s6_ffi", ffi1, 3'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
